// File: rtl/wb_ram_pkg.sv
// wb_ram_pkg: shared constants and address decode for the pipelined Wishbone RAM
package wb_ram_pkg;
  localparam int MAXWAITS = 16;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic logic addr_bad(input logic [63:0] adr, input logic [63:0] base,
                                    input logic [63:0] size, input int unsigned bw);
    logic [63:0] m;
    m = (64'd1 << bw) - 64'd1;
    return ((adr & m) != '0) || (adr < base) || (adr >= base + size);
  endfunction
endpackage

// File: rtl/wb_ram_resp_pipe.sv
// wb_ram_resp_pipe: LATENCY-deep {valid,err,data} response shift register with sync flush
// ports: clk, rst_n (async low), flush, in_valid/in_err/in_data -> ack, err, dat_s (0 unless read ack)
module wb_ram_resp_pipe #(
  parameter int LATENCY = 2,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  input  logic          in_err,
  input  logic [DW-1:0] in_data,
  output logic          ack,
  output logic          err,
  output logic [DW-1:0] dat_s
);
  logic [LATENCY-1:0] v, e;
  logic [DW-1:0]      d [LATENCY];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      e <= '0;
      for (int i = 0; i < LATENCY; i++) d[i] <= '0;
    end else begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        v[i] <= v[i-1] & ~flush;
        e[i] <= e[i-1];
        d[i] <= d[i-1];
      end
      v[0] <= in_valid & ~flush;
      e[0] <= in_err;
      d[0] <= in_data;
    end
  end
  assign ack   = v[LATENCY-1] & ~e[LATENCY-1];
  assign err   = v[LATENCY-1] & e[LATENCY-1];
  assign dat_s = ack ? d[LATENCY-1] : '0;
endmodule

// File: rtl/wb_pipelined_ram.sv
// wb_pipelined_ram: pipelined Wishbone B4 slave RAM, fixed latency, bounded outstanding requests
// ports: clk, rst_n (async low), cyc/stb/we/adr/sel/dat_m in; dat_s/ack/err/stall out
// WB_RAM_STALL_INJECT_EN: adds LFSR-driven random stall on top of occupancy stall
module wb_pipelined_ram
  import wb_ram_pkg::*;
#(
  parameter int             DW        = 32,
  parameter int             AW        = 32,
  parameter int             DEPTH     = 1024,
  parameter logic [AW-1:0]  BASE_ADDR = '0,
  parameter int             LATENCY   = 2,
  parameter int             MAX_OUT   = 2,
  parameter logic [15:0]    LFSR_SEED = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cyc,
  input  logic            stb,
  input  logic            we,
  input  logic [AW-1:0]   adr,
  input  logic [DW/8-1:0] sel,
  input  logic [DW-1:0]   dat_m,
  output logic [DW-1:0]   dat_s,
  output logic            ack,
  output logic            err,
  output logic            stall
);
  localparam int BW = $clog2(DW/8);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);
  logic [DW-1:0] mem [DEPTH];
  logic [CW-1:0] count;
  logic [63:0]   off;
  logic [IW-1:0] idx;
  logic [DW-1:0] rd;
  logic          acc, bad, resp, full, unused_cfg;
  assign acc  = cyc & stb & ~stall;
  assign bad  = addr_bad(64'(adr), 64'(BASE_ADDR), 64'(DEPTH) * 64'(DW/8), BW);
  assign off  = 64'(adr) - 64'(BASE_ADDR);
  assign idx  = IW'(off >> BW);
  assign rd   = mem[idx];
  assign resp = ack | err;
  assign full = count == CW'(MAX_OUT);
  always_ff @(posedge clk) begin
    if (acc & we & ~bad)
      for (int b = 0; b < DW/8; b++)
        if (sel[b]) mem[idx][8*b +: 8] <= dat_m[8*b +: 8];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else if (!cyc) count <= '0;
    else if (acc & ~resp) count <= count + CW'(1);
    else if (~acc & resp) count <= count - CW'(1);
  end
`ifdef WB_RAM_STALL_INJECT_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end
  assign stall      = cyc & (full | (lfsr[1:0] == 2'b00));
  assign unused_cfg = ^6'(MAXWAITS);
`else
  assign stall      = cyc & full;
  assign unused_cfg = ^{LFSR_SEED, LFSR_TAPS, 6'(MAXWAITS)};
`endif
  wb_ram_resp_pipe #(.LATENCY(LATENCY), .DW(DW)) u_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (~cyc),
    .in_valid (acc),
    .in_err   (bad),
    .in_data  ((~we & ~bad) ? rd : '0),
    .ack      (ack),
    .err      (err),
    .dat_s    (dat_s)
  );
endmodule
